// File: rtl/sram_port_arb.sv
// Three-requester arbiter (boot, instruction, data) onto a single SRAM port.
// Fixed 3-cycle access: IDLE arbitrates, ACCESS drives the SRAM, RESP returns ready.
`ifndef SRAM_ADDR_W
`define SRAM_ADDR_W 16
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module sram_port_arb #(
    parameter int ADDR_W = `SRAM_ADDR_W,
    parameter int DATA_W = `DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                b_valid,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    input  logic [DATA_W/8-1:0] b_wstrb,
    output logic                b_ready,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                sram_en,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W/8-1:0] sram_wstrb,
    input  logic [DATA_W-1:0]   sram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {G_NONE, G_B, G_I, G_D} grant_t;

    state_t state, state_nx;
    grant_t grant, grant_nx;
    logic   last_d, last_d_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= G_NONE;
            last_d <= 1'b1;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            last_d <= last_d_nx;
        end
    end

    // I wins a tie only when D was the last I/D grant
    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        last_d_nx = last_d;
        unique case (state)
            IDLE: begin
                if (b_valid || i_valid || d_valid) begin
                    state_nx = ACCESS;
                    if (b_valid) begin
                        grant_nx = G_B;
                    end else if (i_valid && (!d_valid || last_d)) begin
                        grant_nx  = G_I;
                        last_d_nx = 1'b0;
                    end else begin
                        grant_nx  = G_D;
                        last_d_nx = 1'b1;
                    end
                end
            end
            ACCESS: state_nx = RESP;
            RESP: begin
                state_nx = IDLE;
                grant_nx = G_NONE;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = G_NONE;
            end
        endcase
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wstrb = '0;
        if (state == ACCESS) begin
            sram_en = 1'b1;
            unique case (1'b1)
                (grant == G_B): begin
                    sram_addr  = b_addr;
                    sram_wdata = b_wdata;
                    sram_wstrb = b_wstrb;
                end
                (grant == G_I): begin
                    sram_addr = i_addr;
                end
                (grant == G_D): begin
                    sram_addr  = d_addr;
                    sram_wdata = d_wdata;
                    sram_wstrb = d_wstrb;
                end
                default: ;
            endcase
        end
    end

    assign b_ready = (state == RESP) && (grant == G_B);
    assign i_ready = (state == RESP) && (grant == G_I);
    assign d_ready = (state == RESP) && (grant == G_D);
    assign i_rdata = sram_rdata;
    assign d_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb with a behavioural SRAM and a response scoreboard.
// Boot writes preload the SRAM; I/D reads are then checked against those values.
module tb_sram_port_arb;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          b_valid, b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [SW-1:0] b_wstrb;
    logic          i_valid, i_ready;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_valid, d_ready;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [SW-1:0] d_wstrb;
    logic          sram_en;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic [SW-1:0] sram_wstrb;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]    port;
        logic [DW-1:0] data;
        bit            rd;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sram_port_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .b_valid(b_valid), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_wstrb(b_wstrb), .b_ready(b_ready),
        .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_ready(i_ready),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ready(d_ready),
        .sram_en(sram_en), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb),
        .sram_rdata(sram_rdata)
    );

    // Word SRAM: read data appears the cycle after sram_en (read-before-write)
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (sram_en) begin
            for (int k = 0; k < SW; k++)
                if (sram_wstrb[k])
                    mem[sram_addr[9:2]][8*k +: 8] <= sram_wdata[8*k +: 8];
            sram_rdata <= mem[sram_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] p, input logic [DW-1:0] d,
                        input bit rd);
        exp_t e;
        e.port = p;
        e.data = d;
        e.rd   = rd;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every ready pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        logic [1:0] p;
        exp_t       e;
        if (b_ready || i_ready || d_ready) begin
            chk("rdy_onehot", 64'($countones({b_ready, i_ready, d_ready})), 1);
            p = b_ready ? 2'd0 : (i_ready ? 2'd1 : 2'd2);
            chk("sb_pending", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_port", p, e.port);
                if (e.rd)
                    chk("sb_rdata", (p == 2'd1) ? i_rdata : d_rdata, e.data);
            end
        end
    end

    task automatic b_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
        b_valid = 1'b1;
        b_addr  = a;
        b_wdata = d;
        b_wstrb = s;
        push(2'd0, '0, 1'b0);
        tick();
        chk("bw_en", sram_en, 1);
        chk("bw_addr", sram_addr, a);
        chk("bw_wdata", sram_wdata, d);
        chk("bw_wstrb", sram_wstrb, s);
        tick();
        chk("bw_rdy", {b_ready, i_ready, d_ready}, 3'b100);
        chk("bw_resp_en", sram_en, 0);
        b_valid = 1'b0;
        b_wstrb = '0;
        tick();
        chk("bw_idle_en", sram_en, 0);
    endtask

    task automatic d_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        d_valid = 1'b1;
        d_addr  = a;
        d_wstrb = '0;
        push(2'd2, d, 1'b1);
        tick();
        chk("dr_en", sram_en, 1);
        chk("dr_addr", sram_addr, a);
        chk("dr_wstrb_acc", sram_wstrb, 0);
        tick();
        chk("dr_rdy", {b_ready, i_ready, d_ready}, 3'b001);
        chk("dr_rdata", d_rdata, d);
        chk("dr_wstrb_resp", sram_wstrb, 0);
        d_valid = 1'b0;
        tick();
        chk("dr_idle_en", sram_en, 0);
    endtask

    initial begin
        rst     = 1'b1;
        b_valid = 1'b0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        #3;
        chk("rst_en", sram_en, 0);
        chk("rst_rdy", {b_ready, i_ready, d_ready}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_en", sram_en, 0);
            chk("idle_rdy", {b_ready, i_ready, d_ready}, 0);
            chk("idle_wstrb", sram_wstrb, 0);
        end

        // Boot beats both CPU ports
        i_valid = 1'b1; i_addr = 16'h0080;
        d_valid = 1'b1; d_addr = 16'h0084;
        d_wstrb = 4'hF; d_wdata = 32'h1111_1111;
        b_write(16'h0010, 32'hDEAD_BEEF, 4'hF);
        i_valid = 1'b0; d_valid = 1'b0; d_wstrb = '0;

        b_write(16'h0040, 32'h1234_5678, 4'hF);
        b_write(16'h0080, 32'hA000_0001, 4'hF);
        b_write(16'h0084, 32'hB000_0002, 4'hF);
        b_write(16'h0044, 32'hFFFF_FFFF, 4'hF);
        b_write(16'h0044, 32'h0000_00AB, 4'h1);

        // Reset brings last_id back to D before the tie test
        rst = 1'b1;
        #2 rst = 1'b0;

        i_valid = 1'b1; i_addr = 16'h0080;
        d_valid = 1'b1; d_addr = 16'h0084; d_wstrb = '0;
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 0) push(2'd1, 32'hA000_0001, 1'b1);
            else            push(2'd2, 32'hB000_0002, 1'b1);
            tick();
            chk("rr_en", sram_en, 1);
            chk("rr_addr", sram_addr, (g % 2 == 0) ? 16'h0080 : 16'h0084);
            tick();
            chk("rr_rdy", {b_ready, i_ready, d_ready},
                (g % 2 == 0) ? 3'b010 : 3'b001);
            tick();
            chk("rr_idle_en", sram_en, 0);
        end
        i_valid = 1'b0; d_valid = 1'b0;

        // Instruction grant must never write, whatever other strobes say
        i_valid = 1'b1;
        d_valid = 1'b1; d_wstrb = 4'hF; d_wdata = 32'h55AA_55AA;
        b_wstrb = 4'hF; b_wdata = 32'hFFFF_FFFF; b_addr = 16'h0084;
        push(2'd1, 32'hA000_0001, 1'b1);
        tick();
        chk("ib_en", sram_en, 1);
        chk("ib_addr", sram_addr, 16'h0080);
        chk("ib_wstrb", sram_wstrb, 0);
        tick();
        chk("ib_rdy", {b_ready, i_ready, d_ready}, 3'b010);
        i_valid = 1'b0;
        tick();
        push(2'd2, '0, 1'b0);
        tick();
        chk("dw_addr", sram_addr, 16'h0084);
        chk("dw_wstrb", sram_wstrb, 4'hF);
        chk("dw_wdata", sram_wdata, 32'h55AA_55AA);
        tick();
        chk("dw_rdy", {b_ready, i_ready, d_ready}, 3'b001);
        d_valid = 1'b0; d_wstrb = '0; b_wstrb = '0;
        tick();

        d_read(16'h0040, 32'h1234_5678);
        d_read(16'h0084, 32'h55AA_55AA);
        d_read(16'h0010, 32'hDEAD_BEEF);
        d_read(16'h0044, 32'hFFFF_FFAB);

        // Reset during ACCESS aborts the access without a ready
        d_valid = 1'b1; d_addr = 16'h0040; d_wstrb = '0;
        tick();
        chk("ra_en", sram_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("ra_en_off", sram_en, 0);
        chk("ra_rdy", {b_ready, i_ready, d_ready}, 0);
        tick();
        chk("ra_rdy_hold", {b_ready, i_ready, d_ready}, 0);
        chk("ra_en_hold", sram_en, 0);
        rst = 1'b0;
        push(2'd2, 32'h1234_5678, 1'b1);
        tick();
        chk("ra_re_en", sram_en, 1);
        chk("ra_re_addr", sram_addr, 16'h0040);
        tick();
        chk("ra_re_rdy", {b_ready, i_ready, d_ready}, 3'b001);
        d_valid = 1'b0;
        tick();

        repeat (3) begin
            tick();
            chk("end_en", sram_en, 0);
        end
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default `SRAM_ADDR_W, meaning the SRAM byte-address width.
REQ-002 SHALL have parameter DATA_W, default `DATA_W, meaning the data width in bits.
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port b_valid  in  1  boot loader write request.
REQ-006 SHALL have ports b_addr/b_wdata/b_wstrb  in  ADDR_W/DATA_W/DATA_W/8  boot loader write address, data and strobes.
REQ-007 SHALL have port b_ready  out  1  boot loader write done.
REQ-008 SHALL have ports i_valid/i_addr  in  1/ADDR_W  CPU instruction read request (read-only port).
REQ-009 SHALL have ports i_rdata/i_ready  out  DATA_W/1  instruction read data and done.
REQ-010 SHALL have ports d_valid/d_addr/d_wdata/d_wstrb  in  1/ADDR_W/DATA_W/DATA_W/8  CPU data request; wstrb==0 means read.
REQ-011 SHALL have ports d_rdata/d_ready  out  DATA_W/1  data read data and done.
REQ-012 SHALL have ports sram_en/sram_addr/sram_wdata/sram_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  single SRAM port; sram_rdata (in, DATA_W) is valid one cycle after sram_en.

Function
REQ-013 SHALL implement the FSM states IDLE, ACCESS and RESP: IDLE->ACCESS when any valid is high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-014 SHALL register a grant (B, I or D) on the IDLE->ACCESS edge; the grant SHALL stay stable until the FSM returns to IDLE.
REQ-015 SHALL give priority to the boot port: b_valid wins over i_valid and d_valid.
REQ-016 SHALL arbitrate I and D round-robin: a 1-bit last_id register, updated only on I/D grants; when both are valid, grant the one not granted last; reset value of last_id is D, so I wins the first tie.
REQ-017 SHALL, in ACCESS only, assert sram_en=1 and drive sram_addr/wdata/wstrb from the granted requester's current inputs (requesters hold them until ready); outside ACCESS, sram_en=0 and sram_wstrb=0.
REQ-018 SHALL force sram_wstrb=0 for an I grant, making the instruction port read-only.
REQ-019 SHALL, in RESP only, pulse exactly one of b_ready/i_ready/d_ready for one cycle, matching the grant.
REQ-020 SHALL drive i_rdata and d_rdata combinationally from sram_rdata; they are meaningful only while the matching ready is high.
REQ-021 SHALL give a fixed latency of valid sampled in IDLE at cycle N -> sram_en at N+1 -> ready at N+2 -> next arbitration at N+3.
REQ-022 SHALL sample requests only in IDLE: valids that rise during ACCESS/RESP wait; a requester dropping valid early is a protocol error, and the access still completes.
REQ-023 SHALL pass sram_addr through unchanged (byte address; word alignment is the requester's responsibility).

Reset
REQ-024 SHALL, while rst=1, asynchronously force state=IDLE, grant cleared, last_id=D, and all of sram_en, b_ready, i_ready, d_ready = 0.
REQ-025 SHALL abort any in-flight access on reset asserted in ACCESS or RESP: no ready is issued, and arbitration restarts in IDLE on the first edge after rst falls.

Verification
REQ-026 SHALL cover boot priority: b_valid=i_valid=d_valid=1 in IDLE, b_addr=0x10, b_wdata=0xDEADBEEF, b_wstrb=0xF -> sram_en at N+1 with addr 0x10 and wstrb 0xF, b_ready at N+2 only.
REQ-027 SHALL cover the round-robin tie: i_valid=d_valid=1 held after reset -> grants I, D, I, D, with i_ready/d_ready alternating every 3 cycles.
REQ-028 SHALL cover a data read: d_valid=1, d_wstrb=0, d_addr=0x40, SRAM returns 0x12345678 -> d_ready=1 with d_rdata=0x12345678 at N+2, and sram_wstrb=0 throughout.
REQ-029 SHALL cover the instruction strobe block: i_valid=1 with the instruction port selected -> sram_wstrb=0 in ACCESS regardless of any other port's strobes.
REQ-030 SHALL cover reset mid-access: rst pulsed during ACCESS -> no ready pulse, sram_en=0 immediately, and the next request is granted normally with 2-cycle latency.
REQ-031 SHALL cover idle behaviour: all valids 0 for 10 cycles -> sram_en=0 and all readies 0.
